// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG block pipeline.
package jpeg_pkg;

    localparam int BLK_SIZE = 8;

    typedef enum logic {
        IDLE,
        READ
    } rd_state_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
module sdp_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write when enabled; read every cycle into the output register.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/raster_to_block.sv
// Raster-to-block converter: ping-pong 8-line strip buffer, written one line
// at a time and read out as consecutive 8x8 blocks, one block row per cycle.
module raster_to_block
    import jpeg_pkg::*;
#(
    parameter int W_IO  = 8,
    parameter int IMG_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [7:0][W_IO-1:0]       in_data,
    input  logic                       in_sof,
    output logic                       out_valid,
    output logic [7:0][W_IO-1:0]       out_data,
    output logic                       out_sob,
    output logic                       out_eob,
    output logic                       out_sof
);

    localparam int BPL   = IMG_W / BLK_SIZE;
    localparam int STRIP = BLK_SIZE * BPL;
    localparam int DEPTH = 2 * STRIP;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(BPL);
    localparam int WIDTH = BLK_SIZE * W_IO;
    localparam logic [CW-1:0] COL_LAST = CW'(BPL - 1);

    // Bank bit selects the half of the RAM; line/row and column/block inside it.
    function automatic logic [AW-1:0] buf_addr(input logic bank, input logic [2:0] line,
                                               input logic [CW-1:0] col);
        return AW'(int'(bank) * STRIP + int'(line) * BPL + int'(col));
    endfunction

    logic [CW-1:0] wcol_q, wcol_d, col_eff;
    logic [2:0]    wline_q, wline_d, line_eff;
    logic          wbank_q, wbank_d;
    logic          wsof_q, wsof_d;
    logic          strip_start, strip_done, wr_en;
    logic [AW-1:0] wr_addr, rd_addr;

    rd_state_e     state_q, state_d;
    logic [CW-1:0] rblk_q, rblk_d;
    logic [2:0]    rrow_q, rrow_d;
    logic          rbank_q, rbank_d;
    logic          rsof_q, rsof_d;
    logic          rd_v;

    logic          v1_q, v1_d, sob1_q, sob1_d, eob1_q, eob1_d, sof1_q, sof1_d;
    logic          out_valid_q, out_valid_d, out_sob_q, out_sob_d;
    logic          out_eob_q, out_eob_d, out_sof_q, out_sof_d;
    logic [7:0][W_IO-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0]     ram_rd_data;

    // Write side: place each beat in the strip, restarting on a mid-strip in_sof.
    always_comb begin
        strip_start = (wcol_q == '0) && (wline_q == '0);
        col_eff     = in_sof ? '0 : wcol_q;
        line_eff    = in_sof ? '0 : wline_q;
        wcol_d      = wcol_q;
        wline_d     = wline_q;
        wbank_d     = wbank_q;
        wsof_d      = wsof_q;
        strip_done  = 1'b0;
        wr_en       = in_valid && !rst;
        if (in_valid) begin
            if (in_sof || strip_start) begin
                wsof_d = in_sof;
            end
            if (col_eff == COL_LAST) begin
                wcol_d = '0;
                if (line_eff == 3'd7) begin
                    wline_d    = '0;
                    wbank_d    = ~wbank_q;
                    strip_done = 1'b1;
                end else begin
                    wline_d = line_eff + 3'd1;
                end
            end else begin
                wcol_d  = col_eff + CW'(1);
                wline_d = line_eff;
            end
        end
        wr_addr = buf_addr(wbank_q, line_eff, col_eff);
    end

    // Read FSM: walk rows inside a block, blocks across the strip, chaining strips.
    always_comb begin
        state_d = state_q;
        rblk_d  = rblk_q;
        rrow_d  = rrow_q;
        rbank_d = rbank_q;
        rsof_d  = rsof_q;
        rd_v    = 1'b0;
        case (state_q)
            IDLE: begin
                if (strip_done) begin
                    state_d = READ;
                    rblk_d  = '0;
                    rrow_d  = '0;
                    rbank_d = wbank_q;
                    rsof_d  = wsof_q;
                end
            end
            READ: begin
                rd_v = 1'b1;
                if (rrow_q == 3'd7) begin
                    rrow_d = '0;
                    if (rblk_q == COL_LAST) begin
                        rblk_d = '0;
                        if (strip_done) begin
                            rbank_d = wbank_q;
                            rsof_d  = wsof_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rblk_d = rblk_q + CW'(1);
                    end
                end else begin
                    rrow_d = rrow_q + 3'd1;
                end
            end
        endcase
        rd_addr = buf_addr(rbank_q, rrow_q, rblk_q);
    end

    // Flag pipeline: flags travel two stages to line up with the RAM read data.
    always_comb begin
        v1_d        = rd_v;
        sob1_d      = rd_v && (rrow_q == 3'd0);
        eob1_d      = rd_v && (rrow_q == 3'd7);
        sof1_d      = rd_v && (rrow_q == 3'd0) && (rblk_q == '0) && rsof_q;
        out_valid_d = v1_q;
        out_sob_d   = sob1_q;
        out_eob_d   = eob1_q;
        out_sof_d   = sof1_q;
        out_data_d  = v1_q ? ram_rd_data : '0;
    end

    // State register for counters, FSM and output flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcol_q      <= '0;
            wline_q     <= '0;
            wbank_q     <= 1'b0;
            wsof_q      <= 1'b0;
            state_q     <= IDLE;
            rblk_q      <= '0;
            rrow_q      <= '0;
            rbank_q     <= 1'b0;
            rsof_q      <= 1'b0;
            v1_q        <= 1'b0;
            sob1_q      <= 1'b0;
            eob1_q      <= 1'b0;
            sof1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sob_q   <= 1'b0;
            out_eob_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wcol_q      <= wcol_d;
            wline_q     <= wline_d;
            wbank_q     <= wbank_d;
            wsof_q      <= wsof_d;
            state_q     <= state_d;
            rblk_q      <= rblk_d;
            rrow_q      <= rrow_d;
            rbank_q     <= rbank_d;
            rsof_q      <= rsof_d;
            v1_q        <= v1_d;
            sob1_q      <= sob1_d;
            eob1_q      <= eob1_d;
            sof1_q      <= sof1_d;
            out_valid_q <= out_valid_d;
            out_sob_q   <= out_sob_d;
            out_eob_q   <= out_eob_d;
            out_sof_q   <= out_sof_d;
            out_data_q  <= out_data_d;
        end
    end

    sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sob   = out_sob_q;
    assign out_eob   = out_eob_q;
    assign out_sof   = out_sof_q;

endmodule

// File: tb/tb_raster_to_block.sv
// Bench for raster_to_block: strip-level pixel model predicting every output
// row and the cycle it appears, plus literal expectations on captured rows.
module tb_raster_to_block;

    localparam int W_IO  = 8;
    localparam int IMG_W = 16;
    localparam int BPL   = IMG_W / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    logic [7:0][W_IO-1:0] in_data = '0;
    logic out_valid, out_sob, out_eob, out_sof;
    logic [7:0][W_IO-1:0] out_data;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        bit          sob;
        bit          eob;
        bit          sof;
    } exp_t;

    typedef struct {
        logic [63:0] data;
        bit          sob;
        bit          eob;
        bit          sof;
    } obs_t;

    exp_t expQ[$];
    obs_t obsQ[$];
    logic [7:0] pixels [8][IMG_W];
    int  beatIdx = 0;
    bit  curSof = 1'b0;
    int  cyc = 0;
    bit  cmpEn = 1'b0;
    int  checks = 0;
    int  failures = 0;

    raster_to_block #(
        .W_IO  (W_IO),
        .IMG_W (IMG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sob   (out_sob),
        .out_eob   (out_eob),
        .out_sof   (out_sof)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle number: value after rising edge k is k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat; when a strip of 8 lines is complete, predict its 2*8 rows.
    task automatic applyStimulus(input logic [7:0][7:0] data, input bit sof);
        int   line;
        int   col;
        exp_t ent;
        waitCycle();
        in_valid = 1'b1;
        in_data  = data;
        in_sof   = sof;
        if (sof) begin
            beatIdx = 0;
            curSof  = 1'b1;
        end else if (beatIdx == 0) begin
            curSof = 1'b0;
        end
        line = beatIdx / BPL;
        col  = beatIdx % BPL;
        for (int i = 0; i < 8; i++) pixels[line][col * 8 + i] = data[i];
        beatIdx++;
        if (beatIdx == 8 * BPL) begin
            for (int b = 0; b < BPL; b++) begin
                for (int r = 0; r < 8; r++) begin
                    ent.cyc = cyc + 3 + b * 8 + r;
                    for (int i = 0; i < 8; i++) ent.data[i * 8 +: 8] = pixels[r][b * 8 + i];
                    ent.sob = (r == 0);
                    ent.eob = (r == 7);
                    ent.sof = (r == 0) && (b == 0) && curSof;
                    expQ.push_back(ent);
                end
            end
            beatIdx = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            waitCycle();
            in_valid = 1'b0;
            in_sof   = 1'b0;
            in_data  = '0;
        end
    endtask

    // One strip of 8 lines starting at image line firstLine; pattern or random pixels.
    task automatic sendStrip(input int firstLine, input bit sof, input bit rnd, input int maxGap);
        logic [7:0][7:0] d;
        int line;
        int col;
        for (int beat = 0; beat < 8 * BPL; beat++) begin
            line = firstLine + beat / BPL;
            col  = beat % BPL;
            for (int i = 0; i < 8; i++)
                d[i] = rnd ? 8'($urandom) : 8'(line * 16 + col * 8 + i);
            applyStimulus(d, sof && (beat == 0));
            if (maxGap > 0) idle($urandom_range(maxGap, 0));
        end
    endtask

    // Synchronous reset pulse with a junk beat offered during it.
    task automatic doReset();
        waitCycle();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = 64'hEEEE_EEEE_EEEE_EEEE;
        while (expQ.size() > 0 && expQ[expQ.size() - 1].cyc > cyc) expQ.delete(expQ.size() - 1);
        beatIdx = 0;
        curSof  = 1'b0;
        waitCycle();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        @(negedge clk);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_data", 64'(out_data), 64'd0);
        checkOutput("rst_sob", 64'(out_sob), 64'd0);
        checkOutput("rst_eob", 64'(out_eob), 64'd0);
        checkOutput("rst_sof", 64'(out_sof), 64'd0);
    endtask

    task automatic checkObs(input int idx, input string name, input logic [63:0] data,
                            input bit sob, input bit eob, input bit sof);
        if (idx >= obsQ.size()) begin
            checkOutput({name, "_present"}, 64'(obsQ.size()), 64'(idx + 1));
        end else begin
            checkOutput({name, "_data"}, obsQ[idx].data, data);
            checkOutput({name, "_flags"}, {61'd0, obsQ[idx].sob, obsQ[idx].eob, obsQ[idx].sof},
                        {61'd0, sob, eob, sof});
        end
    endtask

    // Per-cycle comparison of the DUT against the model's predicted schedule.
    always @(negedge clk) begin
        if (cmpEn) begin
            if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
                checkOutput("row_valid", 64'(out_valid), 64'd1);
                checkOutput("row_data", 64'(out_data), expQ[0].data);
                checkOutput("row_sob", 64'(out_sob), 64'(expQ[0].sob));
                checkOutput("row_eob", 64'(out_eob), 64'(expQ[0].eob));
                checkOutput("row_sof", 64'(out_sof), 64'(expQ[0].sof));
                expQ.pop_front();
            end else begin
                checkOutput("idle_valid", 64'(out_valid), 64'd0);
                checkOutput("idle_flags", {61'd0, out_sob, out_eob, out_sof}, 64'd0);
            end
            if (out_valid) obsQ.push_back('{out_data, out_sob, out_eob, out_sof});
        end
    end

    initial begin
        doReset();
        cmpEn = 1'b1;

        $display("[TB] single strip, full rate");
        obsQ.delete();
        sendStrip(0, 1'b1, 1'b0, 0);
        idle(25);
        checkOutput("t1_count", 64'(obsQ.size()), 64'd16);
        checkObs(0, "t1_b0r0", 64'h0706050403020100, 1'b1, 1'b0, 1'b1);
        checkObs(1, "t1_b0r1", 64'h1716151413121110, 1'b0, 1'b0, 1'b0);
        checkObs(7, "t1_b0r7", 64'h7776757473727170, 1'b0, 1'b1, 1'b0);
        checkObs(8, "t1_b1r0", 64'h0F0E0D0C0B0A0908, 1'b1, 1'b0, 1'b0);
        checkObs(11, "t1_b1r3", 64'h3F3E3D3C3B3A3938, 1'b0, 1'b0, 1'b0);
        checkObs(15, "t1_b1r7", 64'h7F7E7D7C7B7A7978, 1'b0, 1'b1, 1'b0);

        $display("[TB] single strip, random gaps");
        obsQ.delete();
        sendStrip(0, 1'b1, 1'b0, 5);
        idle(25);
        checkOutput("t2_count", 64'(obsQ.size()), 64'd16);
        checkObs(0, "t2_b0r0", 64'h0706050403020100, 1'b1, 1'b0, 1'b1);
        checkObs(15, "t2_b1r7", 64'h7F7E7D7C7B7A7978, 1'b0, 1'b1, 1'b0);

        $display("[TB] two strips back to back");
        obsQ.delete();
        sendStrip(0, 1'b1, 1'b0, 0);
        sendStrip(8, 1'b0, 1'b0, 0);
        idle(40);
        checkOutput("t3_count", 64'(obsQ.size()), 64'd32);
        checkObs(16, "t3_s1b0r0", 64'h8786858483828180, 1'b1, 1'b0, 1'b0);
        checkObs(31, "t3_s1b1r7", 64'hFFFEFDFCFBFAF9F8, 1'b0, 1'b1, 1'b0);

        $display("[TB] sof restart after 5 beats");
        obsQ.delete();
        applyStimulus(64'hA7A6A5A4A3A2A1A0, 1'b1);
        for (int i = 1; i < 5; i++) applyStimulus({8{8'(8'hB0 + i)}}, 1'b0);
        sendStrip(0, 1'b1, 1'b0, 0);
        idle(25);
        checkOutput("t4_count", 64'(obsQ.size()), 64'd16);
        checkObs(0, "t4_b0r0", 64'h0706050403020100, 1'b1, 1'b0, 1'b1);
        checkObs(9, "t4_b1r1", 64'h1F1E1D1C1B1A1918, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset during block 1 readout");
        obsQ.delete();
        sendStrip(0, 1'b1, 1'b1, 0);
        idle(10);
        doReset();
        idle(20);
        checkOutput("t5_count_mid", 64'(obsQ.size()), 64'd9);
        sendStrip(0, 1'b1, 1'b0, 0);
        idle(25);
        checkOutput("t5_count", 64'(obsQ.size()), 64'd25);
        checkObs(9, "t5_new_b0r0", 64'h0706050403020100, 1'b1, 1'b0, 1'b1);

        $display("[TB] random frame, three strips");
        sendStrip(0, 1'b1, 1'b1, 3);
        sendStrip(8, 1'b0, 1'b1, 3);
        sendStrip(16, 1'b0, 1'b1, 0);
        idle(40);

        checkOutput("drain", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
